awg_frame_parser: RTL
=====================

// Module: awg_frame_parser
// PURPOSE
//  Sits between the ftdi_245fifo_top RX AXI-stream (clk100 domain) and the AWG sample FIFO writer.
//  Strips and decodes the per-frame header: magic, trigger mode, 32-bit length.
//  Forwards exactly <length> payload bytes downstream with tlast on the final byte.
//  Flags malformed or stalled frames on a sticky error and resynchronises on the next magic byte.
// PARAMETERS
//  MAGIC          8'hA5      header sync byte
//  MAX_LEN        32'd16384  largest accepted payload; longer frames are drained, not forwarded
//  TIMEOUT_CYCLES 1_000_000  idle clk100 cycles allowed mid-frame (header or payload) before abort
// PORTS
//  clk100        in   1   system clock, 100 MHz
//  rstn_async    in   1   asynchronous active-low reset
//  rx_tvalid     in   1   upstream byte valid
//  rx_tdata      in   8   upstream byte
//  rx_tready     out  1   upstream ready
//  out_tvalid    out  1   payload byte valid
//  out_tdata     out  8   payload byte
//  out_tlast     out  1   last payload byte of frame
//  out_tready    in   1   downstream ready (sample FIFO not full)
//  trigger_mode  out  8   mode byte of current/last frame
//  frame_len     out  32  length field of current/last frame
//  frame_start   out  1   1-cycle pulse: header accepted (length <= MAX_LEN)
//  frame_done    out  1   1-cycle pulse: last payload byte accepted, or zero-length header done
//  error         out  1   sticky error flag
//  error_clr     in   1   synchronous clear of error (wins over a same-cycle set)
//  state_dbg     out  3   current state encoding, for logic analyser
// BEHAVIOUR
//  Reset: state=S_MAGIC; all outputs 0 except rx_tready=1; trigger_mode, frame_len and counters 0.
//  Byte accepted = rx_tvalid & rx_tready. Header fields change only on accepted bytes.
//  States:
//   S_MAGIC (0): rx_tready=1.
//    - byte==MAGIC -> S_MODE.
//    - Otherwise discard, set error, stay.
//   S_MODE (1): rx_tready=1. Byte -> trigger_mode; byte_idx=0; -> S_LEN.
//   S_LEN (2): rx_tready=1. Little-endian: byte into frame_len[8*byte_idx +: 8].
//    - On 4th byte (idx 3), decide on full 32-bit value L:
//      L==0 -> frame_done pulse, S_MAGIC.
//      L<=MAX_LEN -> frame_start pulse, remaining=L, S_PAYLOAD.
//      L>MAX_LEN -> set error, remaining=L, S_DRAIN.
//   S_PAYLOAD (3): combinational pass-through, zero latency.
//    - out_tvalid=rx_tvalid; out_tdata=rx_tdata; rx_tready=out_tready.
//    - out_tlast = (remaining==1).
//    - On transfer, remaining decrements.
//    - Transfer with remaining==1 -> frame_done pulse next cycle, S_MAGIC.
//   S_DRAIN (4): rx_tready=1, out_tvalid=0.
//    - Consume remaining bytes, then S_MAGIC.
//    - No frame_done pulse.
//  All other states: out_tvalid=0 and out_tlast=0.
//  Timeout: idle counter clears on every accepted byte and whenever state==S_MAGIC.
//   - In S_PAYLOAD, also clears every cycle rx_tvalid=1 (a downstream stall is not a timeout).
//   - Reaching TIMEOUT_CYCLES in S_MODE/S_LEN/S_PAYLOAD/S_DRAIN -> set error, S_MAGIC.
//   - An aborted payload issues no tlast and no frame_done.
//  remaining is 32 bits; no wrap: decrement only when nonzero.
//  Pulses frame_start/frame_done are registered: high in the cycle after the causing byte.
//  Async reset mid-frame returns to S_MAGIC immediately; a partial frame is lost.
//  Illegal state encoding -> error, S_MAGIC.
// TESTING
//  1. A5,07,03,00,00,00,11,22,33 with out_tready=1 -> outputs 11,22,33.
//     tlast on 33; trigger_mode=07; frame_len=3; one frame_start, one frame_done; error=0.
//  2. Same frame, out_tready toggling 1/0 each cycle -> same 3 bytes, in order, no loss or duplication.
//     rx_tready mirrors out_tready in payload.
//  3. 5A, then valid zero-length frame A5,01,00,00,00,00 -> error=1 after 5A.
//     frame_done pulse, no out_tvalid.
//     error_clr -> error=0.
//  4. A5,00,01,40,00,00 (L=16385 > MAX_LEN) then 16385 bytes then A5,.. -> error=1.
//     out_tvalid never high; next frame parsed normally.
//  5. A5,02,02,00,00,00,AA then rx_tvalid=0 for TIMEOUT_CYCLES -> AA forwarded.
//     Then error=1, state_dbg=0, no tlast.
//     Following valid frame forwards correctly.
//  6. rstn_async low while in S_PAYLOAD with remaining=100 -> outputs at reset values immediately.
//     A fresh frame after release works.

Source files
------------

// File: rtl/awg_frame_parser.sv
// ---------------------------------------------------------------------------
// awg_frame_parser
//
// Sits between the FTDI RX AXI-stream and the AWG sample FIFO writer. It
// parses a per-frame header (magic byte, trigger mode byte, 32-bit
// little-endian length) and then passes exactly <length> payload bytes
// downstream, with tlast on the final byte. Frames longer than MAX_LEN are
// drained and not forwarded. Stray bytes, oversize frames, stalled frames
// and corrupted state all raise a sticky error. After any of these the
// parser resynchronises on the next magic byte.
//
// Ports
//   clk100        in   1   system clock
//   rstn_async    in   1   asynchronous active-low reset
//   rx_tvalid     in   1   upstream byte valid
//   rx_tdata      in   8   upstream byte
//   rx_tready     out  1   upstream ready (follows out_tready during payload)
//   out_tvalid    out  1   payload byte valid
//   out_tdata     out  8   payload byte
//   out_tlast     out  1   last payload byte of frame
//   out_tready    in   1   downstream ready
//   trigger_mode  out  8   mode byte of current/last frame
//   frame_len     out  32  length field of current/last frame
//   frame_start   out  1   one-cycle pulse after an accepted header
//   frame_done    out  1   one-cycle pulse after the last payload byte or a
//                          zero-length header
//   error         out  1   sticky error flag
//   error_clr     in   1   synchronous clear of error (beats a same-cycle set)
//   state_dbg     out  3   current state encoding
//
// The payload path is a zero-latency combinational pass-through, so that
// the FIFO writer sees no extra pipeline stage. All other outputs are
// registered.
// ---------------------------------------------------------------------------
module awg_frame_parser #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter logic [31:0] MAX_LEN        = 32'd16384,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk100,
    input  logic        rstn_async,
    input  logic        rx_tvalid,
    input  logic [7:0]  rx_tdata,
    output logic        rx_tready,
    output logic        out_tvalid,
    output logic [7:0]  out_tdata,
    output logic        out_tlast,
    input  logic        out_tready,
    output logic [7:0]  trigger_mode,
    output logic [31:0] frame_len,
    output logic        frame_start,
    output logic        frame_done,
    output logic        error,
    input  logic        error_clr,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0]  S_MAGIC   = 3'd0;
    localparam logic [2:0]  S_MODE    = 3'd1;
    localparam logic [2:0]  S_LEN     = 3'd2;
    localparam logic [2:0]  S_PAYLOAD = 3'd3;
    localparam logic [2:0]  S_DRAIN   = 3'd4;

    // The idle counter aborts when it already holds this value and one more
    // idle cycle occurs. That gives exactly TIMEOUT_CYCLES idle cycles.
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_r;
    logic [7:0]  trigger_mode_r;
    logic [31:0] frame_len_r;
    logic [1:0]  byte_idx_r;
    logic [31:0] remaining_r;
    logic [31:0] idle_cnt_r;
    logic        frame_start_r;
    logic        frame_done_r;
    logic        error_r;

    logic        rx_tready_s;
    logic        out_tvalid_s;
    logic [7:0]  out_tdata_s;
    logic        out_tlast_s;
    logic        accept_s;
    logic [31:0] len_full_s;

    logic [2:0]  state_nxt_s;
    logic [7:0]  trigger_mode_nxt_s;
    logic [31:0] frame_len_nxt_s;
    logic [1:0]  byte_idx_nxt_s;
    logic [31:0] remaining_nxt_s;
    logic [31:0] idle_cnt_nxt_s;
    logic        frame_start_nxt_s;
    logic        frame_done_nxt_s;
    logic        error_set_s;

    // Stream handshake: transparent pass-through in payload, always ready elsewhere
    always_comb begin
        rx_tready_s  = 1'b1;
        out_tvalid_s = 1'b0;
        out_tdata_s  = 8'h00;
        out_tlast_s  = 1'b0;
        if (state_r == S_PAYLOAD) begin
            rx_tready_s  = out_tready;
            out_tvalid_s = rx_tvalid;
            out_tdata_s  = rx_tdata;
            out_tlast_s  = (remaining_r == 32'd1);
        end else begin
            rx_tready_s  = 1'b1;
            out_tvalid_s = 1'b0;
            out_tdata_s  = 8'h00;
            out_tlast_s  = 1'b0;
        end
    end

    assign accept_s   = rx_tvalid & rx_tready_s;
    // The length as it will be once the final (most significant) byte lands
    assign len_full_s = {rx_tdata, frame_len_r[23:0]};

    // Next-state, header decode, payload counting and idle timeout
    always_comb begin
        state_nxt_s        = state_r;
        trigger_mode_nxt_s = trigger_mode_r;
        frame_len_nxt_s    = frame_len_r;
        byte_idx_nxt_s     = byte_idx_r;
        remaining_nxt_s    = remaining_r;
        frame_start_nxt_s  = 1'b0;
        frame_done_nxt_s   = 1'b0;
        error_set_s        = 1'b0;
        idle_cnt_nxt_s     = 32'd0;

        case (state_r)
            S_MAGIC: begin
                if (accept_s) begin
                    if (rx_tdata == MAGIC) begin
                        state_nxt_s = S_MODE;
                    end else begin
                        error_set_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_MAGIC;
                end
            end
            S_MODE: begin
                if (accept_s) begin
                    trigger_mode_nxt_s = rx_tdata;
                    byte_idx_nxt_s     = 2'd0;
                    state_nxt_s        = S_LEN;
                end else begin
                    state_nxt_s = S_MODE;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    frame_len_nxt_s[8*byte_idx_r +: 8] = rx_tdata;
                    byte_idx_nxt_s = byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        if (len_full_s == 32'd0) begin
                            frame_done_nxt_s = 1'b1;
                            state_nxt_s      = S_MAGIC;
                        end else if (len_full_s <= MAX_LEN) begin
                            frame_start_nxt_s = 1'b1;
                            remaining_nxt_s   = len_full_s;
                            state_nxt_s       = S_PAYLOAD;
                        end else begin
                            error_set_s     = 1'b1;
                            remaining_nxt_s = len_full_s;
                            state_nxt_s     = S_DRAIN;
                        end
                    end else begin
                        state_nxt_s = S_LEN;
                    end
                end else begin
                    state_nxt_s = S_LEN;
                end
            end
            S_PAYLOAD, S_DRAIN: begin
                if (remaining_r == 32'd0) begin
                    // Cannot be reached legitimately; treat as corruption.
                    error_set_s = 1'b1;
                    state_nxt_s = S_MAGIC;
                end else if (accept_s) begin
                    remaining_nxt_s = remaining_r - 32'd1;
                    if (remaining_r == 32'd1) begin
                        frame_done_nxt_s = (state_r == S_PAYLOAD);
                        state_nxt_s      = S_MAGIC;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                error_set_s = 1'b1;
                state_nxt_s = S_MAGIC;
            end
        endcase

        // A downstream stall with data waiting upstream does not count as idle.
        if ((state_r == S_MAGIC) || accept_s ||
            ((state_r == S_PAYLOAD) && rx_tvalid)) begin
            idle_cnt_nxt_s = 32'd0;
        end else if (idle_cnt_r == IDLE_LAST) begin
            idle_cnt_nxt_s = 32'd0;
            error_set_s    = 1'b1;
            state_nxt_s    = S_MAGIC;
        end else begin
            idle_cnt_nxt_s = idle_cnt_r + 32'd1;
        end
    end

    // State, header fields, counters and pulse registers
    always_ff @(posedge clk100 or negedge rstn_async) begin
        if (!rstn_async) begin
            state_r        <= S_MAGIC;
            trigger_mode_r <= 8'h00;
            frame_len_r    <= 32'd0;
            byte_idx_r     <= 2'd0;
            remaining_r    <= 32'd0;
            idle_cnt_r     <= 32'd0;
            frame_start_r  <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            trigger_mode_r <= trigger_mode_nxt_s;
            frame_len_r    <= frame_len_nxt_s;
            byte_idx_r     <= byte_idx_nxt_s;
            remaining_r    <= remaining_nxt_s;
            idle_cnt_r     <= idle_cnt_nxt_s;
            frame_start_r  <= frame_start_nxt_s;
            frame_done_r   <= frame_done_nxt_s;
        end
    end

    // Sticky error flag; the clear has priority over a same-cycle set
    always_ff @(posedge clk100 or negedge rstn_async) begin
        if (!rstn_async) begin
            error_r <= 1'b0;
        end else if (error_clr) begin
            error_r <= 1'b0;
        end else if (error_set_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign rx_tready    = rx_tready_s;
    assign out_tvalid   = out_tvalid_s;
    assign out_tdata    = out_tdata_s;
    assign out_tlast    = out_tlast_s;
    assign trigger_mode = trigger_mode_r;
    assign frame_len    = frame_len_r;
    assign frame_start  = frame_start_r;
    assign frame_done   = frame_done_r;
    assign error        = error_r;
    assign state_dbg    = state_r;

endmodule
